laplace_cross_window: RTL and testbench

Streaming window generator directly upstream of the 5-input approximate Laplace kernel. It accepts a raster-order 8-bit grayscale pixel stream and buffers two image lines. For every interior pixel it emits the cross-shaped neighbourhood b (up), d (left), e (centre), f (right), h (down), registered with a valid/ready handshake, so the combinational kernel can sit on its output.

---
 rtl/laplace_cross_window.sv | 151 +++++++++++++++
 tb/tb_laplace_cross_window.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/laplace_cross_window.sv
// Cross-shaped 3x3 neighbourhood generator (b/d/e/f/h) for a raster pixel stream.
// Optional completed-frame counter enabled by defining LAPWIN_FRAME_CNT_EN.
module laplace_cross_window #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_pixel,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] b,
    output logic [7:0] d,
    output logic [7:0] e,
    output logic [7:0] f,
    output logic [7:0] h,
    output logic       out_last
`ifdef LAPWIN_FRAME_CNT_EN
    ,
    output logic [15:0] frame_count
`endif
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    logic [CW-1:0] col_r, col_nxt_s;
    logic [RW-1:0] row_r, row_nxt_s;
    logic [7:0]    lb1_r [IMG_WIDTH];
    logic [7:0]    lb2_r [IMG_WIDTH];
    logic [7:0]    lb1_rd_s, lb2_rd_s;
    logic [7:0]    top_d1_r, mid_d1_r, mid_d2_r, bot_d1_r;
    logic [7:0]    b_r, d_r, e_r, f_r, h_r;
    logic          out_valid_r, out_valid_nxt_s, out_last_r;
    logic          accept_s, consume_s, emit_s, col_last_s, row_last_s;

    assign in_ready   = !out_valid_r || out_ready;
    assign accept_s   = in_valid && in_ready;
    assign consume_s  = out_valid_r && out_ready;
    assign col_last_s = (col_r == CW'(IMG_WIDTH - 1));
    assign row_last_s = (row_r == RW'(IMG_HEIGHT - 1));
    // Border pixels never emit, which also keeps stale line-buffer data out of the output.
    assign emit_s     = accept_s && (row_r >= RW'(2)) && (col_r >= CW'(2));
    assign lb1_rd_s   = lb1_r[col_r];
    assign lb2_rd_s   = lb2_r[col_r];

    assign out_valid = out_valid_r;
    assign out_last  = out_last_r;
    assign b = b_r;
    assign d = d_r;
    assign e = e_r;
    assign f = f_r;
    assign h = h_r;

    // Raster position and output-valid next state.
    always_comb begin
        col_nxt_s       = col_r;
        row_nxt_s       = row_r;
        out_valid_nxt_s = out_valid_r;
        if (accept_s) begin
            if (col_last_s) begin
                col_nxt_s = {CW{1'b0}};
                if (row_last_s) begin
                    row_nxt_s = {RW{1'b0}};
                end else begin
                    row_nxt_s = row_r + RW'(1);
                end
            end else begin
                col_nxt_s = col_r + CW'(1);
            end
        end else begin
            col_nxt_s = col_r;
        end
        if (emit_s) begin
            out_valid_nxt_s = 1'b1;
        end else if (consume_s) begin
            out_valid_nxt_s = 1'b0;
        end else begin
            out_valid_nxt_s = out_valid_r;
        end
    end

    // Line buffers are intentionally not reset.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            lb2_r[col_r] <= lb1_rd_s;
            lb1_r[col_r] <= in_pixel;
        end
    end

    // Position counters and neighbourhood shift registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_r    <= {CW{1'b0}};
            row_r    <= {RW{1'b0}};
            top_d1_r <= 8'h00;
            mid_d1_r <= 8'h00;
            mid_d2_r <= 8'h00;
            bot_d1_r <= 8'h00;
        end else begin
            col_r <= col_nxt_s;
            row_r <= row_nxt_s;
            if (accept_s) begin
                top_d1_r <= lb2_rd_s;
                mid_d2_r <= mid_d1_r;
                mid_d1_r <= lb1_rd_s;
                bot_d1_r <= in_pixel;
            end
        end
    end

    // Single-entry registered output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            b_r         <= 8'h00;
            d_r         <= 8'h00;
            e_r         <= 8'h00;
            f_r         <= 8'h00;
            h_r         <= 8'h00;
        end else begin
            out_valid_r <= out_valid_nxt_s;
            if (emit_s) begin
                b_r        <= top_d1_r;
                d_r        <= mid_d2_r;
                e_r        <= mid_d1_r;
                f_r        <= lb1_rd_s;
                h_r        <= bot_d1_r;
                out_last_r <= row_last_s && col_last_s;
            end
        end
    end

`ifdef LAPWIN_FRAME_CNT_EN
    logic [15:0] frame_cnt_r;
    assign frame_count = frame_cnt_r;

    // Counts frames whose last window has been taken downstream; wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_r <= 16'h0000;
        end else if (consume_s && out_last_r) begin
            frame_cnt_r <= frame_cnt_r + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_laplace_cross_window.sv
// Randomised and directed bench for laplace_cross_window on a 4x4 image,
// checked every cycle against an image-array reference model.
module tb_laplace_cross_window;
    localparam int W = 4;
    localparam int H = 4;

    typedef struct packed {
        logic [7:0] b, d, e, f, h;
        logic       last;
    } win_t;

    logic clk = 1'b0;
    logic rst_n, in_valid, in_ready, out_valid, out_ready, out_last;
    logic [7:0] in_pixel, b, d, e, f, h;
`ifdef LAPWIN_FRAME_CNT_EN
    logic [15:0] frame_count;
`endif

    laplace_cross_window #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_pixel(in_pixel), .out_valid(out_valid), .out_ready(out_ready),
        .b(b), .d(d), .e(e), .f(f), .h(h), .out_last(out_last)
`ifdef LAPWIN_FRAME_CNT_EN
        , .frame_count(frame_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    win_t expq[$];
    win_t got[$];
    win_t ref_seq[$];
    logic [7:0] img [H][W];
    int mr = 0, mc = 0;
    bit rnd_ready = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: remember every pixel at its raster position, derive windows from it.
    always @(posedge clk) begin
        if (!rst_n) begin
            expq.delete();
            mr = 0;
            mc = 0;
        end else begin
            if (out_valid && out_ready && expq.size() != 0) begin
                got.push_back({b, d, e, f, h, out_last});
                void'(expq.pop_front());
            end
            if (in_valid && in_ready) begin
                img[mr][mc] = in_pixel;
                if (mr >= 2 && mc >= 2)
                    expq.push_back('{img[mr-2][mc-1], img[mr-1][mc-2], img[mr-1][mc-1],
                                     img[mr-1][mc], img[mr][mc-1], (mr == H-1 && mc == W-1)});
                mc++;
                if (mc == W) begin
                    mc = 0;
                    mr = (mr == H-1) ? 0 : mr + 1;
                end
            end
        end
    end

    // Compare DUT outputs with the model every cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_out_valid", 64'(out_valid), 64'd0);
            check("rst_outputs", 64'({b, d, e, f, h, out_last}), 64'd0);
        end else begin
            check("out_valid", 64'(out_valid), 64'(expq.size() != 0));
            check("in_ready", 64'(in_ready), 64'(expq.size() == 0 || out_ready));
            if (expq.size() != 0 && out_valid)
                check("window", 64'({b, d, e, f, h, out_last}), 64'(expq[0]));
        end
    end

    // Random downstream backpressure when enabled.
    always @(posedge clk) begin
        if (rnd_ready) begin
            #1 out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send_pixel(input logic [7:0] p);
        bit acc;
        int n = 0;
        in_valid = 1'b1;
        in_pixel = p;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 1000);
        if (!acc) check("accept_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    // gap < 0 means random idle cycles between pixels.
    task automatic send_frame(input logic [7:0] base, input int gap, input bit rnd);
        int g;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                send_pixel(rnd ? 8'($urandom) : 8'(base + 16*r + c));
                g = (gap < 0) ? $urandom_range(0, 2) : gap;
                repeat (g) begin
                    @(posedge clk);
                    #1;
                end
            end
    endtask

    task automatic drain();
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic check_seq(input string name);
        check({name, "_count"}, 64'(got.size()), 64'(ref_seq.size()));
        for (int i = 0; i < got.size() && i < ref_seq.size(); i++)
            check(name, 64'(got[i]), 64'(ref_seq[i]));
    endtask

    initial begin
        win_t w, hold_w;
        int lasts;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_pixel = 8'h00;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        check("in_ready_after_reset", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 out_ready = 1'b1;

        // Basic 4x4 frame with hand-computed first/last windows.
        got.delete();
        send_frame(8'h00, 0, 1'b0);
        drain();
        check("t1_count", 64'(got.size()), 64'd4);
        w = (got.size() > 0) ? got[0] : '0;
        check("t1_first", 64'(w), 64'(win_t'{8'd1, 8'd16, 8'd17, 8'd18, 8'd33, 1'b0}));
        w = (got.size() > 3) ? got[3] : '0;
        check("t1_last", 64'(w), 64'(win_t'{8'd18, 8'd33, 8'd34, 8'd35, 8'd50, 1'b1}));
        ref_seq = got;

        // Backpressure held for 5 cycles on the first window.
        got.delete();
        fork
            send_frame(8'h00, 0, 1'b0);
            begin
                int n = 0;
                do begin
                    @(posedge clk);
                    #1;
                    n++;
                end while (!out_valid && n < 200);
                out_ready = 1'b0;
                hold_w = {b, d, e, f, h, out_last};
                repeat (5) begin
                    @(negedge clk);
                    check("bp_in_ready", 64'(in_ready), 64'd0);
                    check("bp_stable", 64'({b, d, e, f, h, out_last}), 64'(hold_w));
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        check_seq("bp_seq");

        // Two back-to-back frames, second offset by 0x80.
        got.delete();
        send_frame(8'h00, 0, 1'b0);
        send_frame(8'h80, 0, 1'b0);
        drain();
        check("b2b_count", 64'(got.size()), 64'd8);
        w = (got.size() > 4) ? got[4] : '0;
        check("b2b_f2_b", 64'(w.b), 64'h81);
        check("b2b_f2_e", 64'(w.e), 64'h91);

        // in_valid toggling every other cycle.
        got.delete();
        send_frame(8'h00, 1, 1'b0);
        drain();
        check_seq("gap_seq");

        // Reset mid-frame, then a full frame.
        send_pixel(8'h00); send_pixel(8'h01); send_pixel(8'h02);
        send_pixel(8'h03); send_pixel(8'h10); send_pixel(8'h11);
        do_reset();
        got.delete();
        send_frame(8'h00, 0, 1'b0);
        drain();
        check_seq("rst_seq");
        lasts = 0;
        foreach (got[i]) lasts += int'(got[i].last);
        check("rst_last_count", 64'(lasts), 64'd1);

        // Random pixels, random valid gaps, random backpressure.
        got.delete();
        rnd_ready = 1'b1;
        repeat (3) send_frame(8'h00, -1, 1'b1);
        rnd_ready = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b1;
        drain();
        check("rnd_count", 64'(got.size()), 64'd12);

`ifdef LAPWIN_FRAME_CNT_EN
        do_reset();
        check("fc_reset", 64'(frame_count), 64'd0);
        for (int i = 1; i <= 3; i++) begin
            send_frame(8'h00, 0, 1'b0);
            drain();
            check("fc_inc", 64'(frame_count), 64'(i));
        end
        force dut.frame_cnt_r = 16'hFFFF;
        #1 release dut.frame_cnt_r;
        send_frame(8'h00, 0, 1'b0);
        drain();
        check("fc_wrap", 64'(frame_count), 64'd0);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
